// File: rtl/cla_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_mp_pkg
// Desc     : Shared types, constants and round-robin pick for cla_mp_sched.
// Revision : 1.0
// ============================================================================
package cla_mp_pkg;

    localparam int WORD_W  = 16;
    localparam int MAX_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // First set bit of valid searching upward from ptr+1 with wrap at n.
    // Scanning from the far end lets the nearest candidate win last.
    function automatic logic [1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [1:0]         ptr,
                                           input int unsigned        n);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = ptr;
        for (int unsigned k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                idx = 2'((32'(ptr) + k) % n);
                if (valid[idx]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_mp_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : cla_mp_rr_arb
// Desc     : Round-robin grant index over NREQ requesters, last-winner pointer.
// Revision : 1.0
// ============================================================================
module cla_mp_rr_arb
    import cla_mp_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] grant,
    output logic            grant_valid
);

    logic [MAX_REQ-1:0] w_valid_ext;
    logic [1:0]         w_ptr_ext;

    assign w_valid_ext = MAX_REQ'(valid);
    assign w_ptr_ext   = 2'(ptr);
    assign grant       = ID_W'(rr_pick(w_valid_ext, w_ptr_ext, NREQ));
    assign grant_valid = |valid;

endmodule
`default_nettype wire

// File: rtl/cla_mp_sched.sv
`default_nettype none
// ============================================================================
// Module   : cla_mp_sched
// Desc     : Shares one external 16-bit adder slice among NREQ requesters,
//            running each WORDS-word addition LSW first with chained carry.
// Options  : CLA_MP_SCHED_SUB_EN adds req_sub (A-B via ~B and carry-in 1).
// Revision : 1.0
// ============================================================================
module cla_mp_sched
    import cla_mp_pkg::*;
#(
    parameter  int WORDS = 4,
    parameter  int NREQ  = 2,
    localparam int ID_W  = $clog2(NREQ),
    localparam int OP_W  = WORD_W * WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
`ifdef CLA_MP_SCHED_SUB_EN
    input  logic [NREQ-1:0]      req_sub,
`endif
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [OP_W-1:0]      rsp_sum,
    output logic                 rsp_cout,
    output logic [WORD_W-1:0]    alu_a,
    output logic [WORD_W-1:0]    alu_b,
    output logic                 alu_cin,
    input  logic [WORD_W-1:0]    alu_sum,
    input  logic                 alu_cout
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic [IDX_W-1:0]    r_idx;
    logic                r_carry;
    logic                r_sub;
    logic                r_cout;
    logic [OP_W-1:0]     r_op_a;
    logic [OP_W-1:0]     r_op_b;
    logic [OP_W-1:0]     r_sum;

    logic [ID_W-1:0]     w_grant;
    logic                w_grant_valid;
    logic                w_handshake;
    logic                w_last;
    logic                w_sel_sub;
    logic [OP_W-1:0]     w_sel_a;
    logic [OP_W-1:0]     w_sel_b;
    logic [WORD_W-1:0]   w_word_a;
    logic [WORD_W-1:0]   w_word_b;

    cla_mp_rr_arb #(
        .NREQ        (NREQ)
    ) u_arb (
        .valid       (req_valid),
        .ptr         (r_rr_ptr),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    assign w_handshake = (r_state == IDLE) && w_grant_valid;
    assign w_last      = (r_idx == IDX_W'(WORDS - 1));
    assign w_sel_a     = req_a[w_grant*OP_W +: OP_W];
    assign w_sel_b     = req_b[w_grant*OP_W +: OP_W];
    assign w_word_a    = r_op_a[r_idx*WORD_W +: WORD_W];
    assign w_word_b    = r_op_b[r_idx*WORD_W +: WORD_W];

`ifdef CLA_MP_SCHED_SUB_EN
    assign w_sel_sub = req_sub[w_grant];
`else
    assign w_sel_sub = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Slice inputs are held at zero outside RUN to keep the datapath quiet.
    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        rsp_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_cin   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    req_ready = NREQ'(1) << w_grant;
                    w_next    = RUN;
                end
            end
            RUN: begin
                alu_a   = w_word_a;
                alu_b   = r_sub ? ~w_word_b : w_word_b;
                alu_cin = r_carry;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Subtract seeds the word-0 carry with 1 to complete the two's complement.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_sub    <= 1'b0;
            r_cout   <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_sum    <= '0;
        end else if (w_handshake) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_sub    <= w_sel_sub;
            r_carry  <= w_sel_sub;
            r_id     <= w_grant;
            r_rr_ptr <= w_grant;
            r_idx    <= '0;
        end else if (r_state == RUN) begin
            r_sum[r_idx*WORD_W +: WORD_W] <= alu_sum;
            r_carry <= alu_cout;
            if (w_last) begin
                r_cout <= alu_cout;
                r_idx  <= '0;
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign rsp_id   = r_id;
    assign rsp_sum  = r_sum;
    assign rsp_cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_cla_mp_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_mp_sched
// Desc     : Randomized scoreboard bench for cla_mp_sched with a behavioural
//            adder slice and a request-level reference model.
// Revision : 1.0
// ============================================================================
module tb_cla_mp_sched;

    localparam int WORDS = 4;
    localparam int NREQ  = 2;
    localparam int OP_W  = 16 * WORDS;
    localparam int ID_W  = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OP_W-1:0] req_a = '0;
    logic [NREQ*OP_W-1:0] req_b = '0;
    logic [NREQ-1:0]      req_sub = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [ID_W-1:0]      rsp_id;
    logic [OP_W-1:0]      rsp_sum;
    logic                 rsp_cout;
    logic [15:0]          alu_a;
    logic [15:0]          alu_b;
    logic                 alu_cin;
    logic [15:0]          alu_sum;
    logic                 alu_cout;

    cla_mp_sched #(
        .WORDS     (WORDS),
        .NREQ      (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef CLA_MP_SCHED_SUB_EN
        .req_sub   (req_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_sum   (alu_sum),
        .alu_cout  (alu_cout)
    );

    always #5 clk = ~clk;

    // Stand-in for the external adder slice.
    assign {alu_cout, alu_sum} = 17'(alu_a) + 17'(alu_b) + 17'(alu_cin);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [OP_W-1:0] sum;
        logic            cout;
    } rsp_t;

    rsp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          hs_cyc = 0;
    int          ptr    = 0;
    bit          known  = 0;
    bit          busy   = 0;
    bit          post_rst = 0;
    logic [OP_W-1:0] m_a;
    logic [OP_W-1:0] m_b_eff;
    logic            m_cin0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int j = 1; j <= NREQ; j++) begin
            int i;
            i = (p + j) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Carry entering word k: overflow of the low k words added together.
    function automatic logic carry_into(input int k);
        logic [127:0] mask;
        logic [127:0] s;
        if (k == 0) return m_cin0;
        mask = (128'd1 << (16 * k)) - 128'd1;
        s    = (128'(m_a) & mask) + (128'(m_b_eff) & mask) + 128'(m_cin0);
        return s[16 * k];
    endfunction

    always @(negedge clk) begin : p_model
        int k;
        int g;
        logic [NREQ-1:0] exp_rdy;
        logic [OP_W:0]   full;
        rsp_t            e;
        cyc++;
        if (known) begin
            exp_rdy = '0;
            if (!busy && (|req_valid)) exp_rdy[pick(req_valid, ptr)] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            if (post_rst) begin
                chk("rst_sum", rsp_sum, 0);
                chk("rst_id", rsp_id, 0);
                chk("rst_cout", rsp_cout, 0);
            end
            k = cyc - hs_cyc;
            if (!busy) begin
                chk("idle_valid", rsp_valid, 0);
                chk("idle_alu", {alu_a, alu_b, alu_cin}, 0);
            end else if (k <= WORDS) begin
                chk("run_valid", rsp_valid, 0);
                chk("run_alu_a", alu_a, 16'(m_a >> (16 * (k - 1))));
                chk("run_alu_b", alu_b, 16'(m_b_eff >> (16 * (k - 1))));
                chk("run_alu_cin", alu_cin, carry_into(k - 1));
            end else begin
                chk("done_valid", rsp_valid, 1);
            end
        end
        if (rst) begin
            known    = 1;
            busy     = 0;
            ptr      = 0;
            post_rst = 1;
            q.delete();
        end else begin
            post_rst = 0;
            if (!busy && (|req_valid)) begin
                g       = pick(req_valid, ptr);
                ptr     = g;
                busy    = 1;
                hs_cyc  = cyc;
                m_a     = req_a[g*OP_W +: OP_W];
                m_cin0  = req_sub[g];
                m_b_eff = m_cin0 ? ~req_b[g*OP_W +: OP_W] : req_b[g*OP_W +: OP_W];
                full    = {1'b0, m_a} + {1'b0, m_b_eff} + (OP_W+1)'(m_cin0);
                e.id    = ID_W'(g);
                e.sum   = full[OP_W-1:0];
                e.cout  = full[OP_W];
                q.push_back(e);
            end else if (busy && ((cyc - hs_cyc) >= WORDS + 1) && rsp_ready) begin
                busy = 0;
            end
        end
    end

    always @(negedge clk) begin : p_monitor
        if (known && rsp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected actual=valid required=none t=%0t", $time);
            end else begin
                chk("rsp_id", rsp_id, q[0].id);
                chk("rsp_sum", rsp_sum, q[0].sum);
                chk("rsp_cout", rsp_cout, q[0].cout);
                if (rsp_ready && !rst) void'(q.pop_front());
            end
        end
    end

    function automatic logic [OP_W-1:0] rnd_op();
        logic [OP_W-1:0] v;
        for (int w = 0; w < WORDS; w++) begin
            case ($urandom_range(0, 3))
                0:       v[16*w +: 16] = 16'h0000;
                1:       v[16*w +: 16] = 16'hFFFF;
                default: v[16*w +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic issue(input int i, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input bit s);
        req_a[i*OP_W +: OP_W] = a;
        req_b[i*OP_W +: OP_W] = b;
        req_sub[i]   = s;
        req_valid[i] = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                @(posedge clk);
                #1;
                req_valid[i] = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL issue_timeout actual=no_grant required=grant req=%0d", i);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            if (!busy && q.size() == 0) return;
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout actual=busy required=idle pending=%0d", q.size());
    endtask

    initial begin : p_stim
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        issue(0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        wait_idle();
        issue(0, {OP_W{1'b1}}, 64'h1, 1'b0);
        wait_idle();
        issue(1, 64'h1234_5678_9ABC_DEF0, 64'hEDCB_A987_6543_2110, 1'b0);
        wait_idle();
`ifdef CLA_MP_SCHED_SUB_EN
        issue(0, 64'h5, 64'h7, 1'b1);
        wait_idle();
        req_sub = '0;
`endif

        // Both requesters valid back to back with a free-running consumer.
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_a[i*OP_W +: OP_W] = rnd_op();
                req_b[i*OP_W +: OP_W] = rnd_op();
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        wait_idle();

        // Consumer stalls long in DONE while the other requester waits.
        rsp_ready = 1'b0;
        issue(1, rnd_op(), rnd_op(), 1'b0);
        req_a[0 +: OP_W] = rnd_op();
        req_b[0 +: OP_W] = rnd_op();
        req_valid[0] = 1'b1;
        repeat (WORDS + 12) @(posedge clk);
        #1 rsp_ready = 1'b1;
        issue(0, req_a[0 +: OP_W], req_b[0 +: OP_W], 1'b0);
        wait_idle();

        // Reset while the slice is working on word 2.
        issue(1, {OP_W{1'b1}}, 64'h1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        issue(0, 64'h0000_0001_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
        wait_idle();

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 3) == 0) req_valid[i] = ~req_valid[i];
                req_a[i*OP_W +: OP_W] = rnd_op();
                req_b[i*OP_W +: OP_W] = rnd_op();
`ifdef CLA_MP_SCHED_SUB_EN
                req_sub[i] = 1'($urandom_range(0, 1));
`endif
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
